// File: rtl/regfile_mp_bypass_sb.sv
// Multi-port register file with same-cycle write->read bypass, highest-port-wins
// write priority and a per-register busy scoreboard (set at issue, clear at writeback).
module regfile_mp_bypass_sb #(
  parameter int DW       = 32,
  parameter int AW       = 5,
  parameter int NRD      = 6,
  parameter int NWR      = 2,
  parameter int ZERO_REG = 1
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic [NRD*AW-1:0] raddr,
  output logic [NRD*DW-1:0] rdata,
  output logic [NRD-1:0]    rbusy,
  input  logic [NWR-1:0]    we,
  input  logic [NWR*AW-1:0] waddr,
  input  logic [NWR*DW-1:0] wdata,
  input  logic [NWR-1:0]    set_en,
  input  logic [NWR*AW-1:0] set_addr
);

  localparam int  DEPTH = 2 ** AW;
  localparam bit  HAS_ZERO = (ZERO_REG != 0);

  logic [DW-1:0]    rf [DEPTH];
  logic [DEPTH-1:0] busy_reg;
  logic [DEPTH-1:0] busy_next;

  logic [AW-1:0] wa  [NWR];
  logic [DW-1:0] wd  [NWR];
  logic [AW-1:0] sa  [NWR];
  logic [NWR-1:0] wr_ok;
  logic [NWR-1:0] set_ok;

  genvar gi;
  generate
    for (gi = 0; gi < NWR; gi++) begin : g_wport
      assign wa[gi]     = waddr[gi*AW +: AW];
      assign wd[gi]     = wdata[gi*DW +: DW];
      assign sa[gi]     = set_addr[gi*AW +: AW];
      // Register 0 is hard-wired when HAS_ZERO: its writes and sets are dropped.
      assign wr_ok[gi]  = we[gi] && !(HAS_ZERO && (wa[gi] == '0));
      assign set_ok[gi] = set_en[gi] && !(HAS_ZERO && (sa[gi] == '0));
    end
  endgenerate

  // Ascending port order: the last non-blocking assignment (highest port) wins.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int r = 0; r < DEPTH; r++) begin
        rf[r] <= '0;
      end
    end else begin
      for (int j = 0; j < NWR; j++) begin
        if (wr_ok[j]) begin
          rf[wa[j]] <= wd[j];
        end
      end
    end
  end

  // Clears applied first so that a same-cycle set of the same register wins.
  always_comb begin
    busy_next = busy_reg;
    for (int j = 0; j < NWR; j++) begin
      if (wr_ok[j]) begin
        busy_next[wa[j]] = 1'b0;
      end
    end
    for (int k = 0; k < NWR; k++) begin
      if (set_ok[k]) begin
        busy_next[sa[k]] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      busy_reg <= '0;
    end else begin
      busy_reg <= busy_next;
    end
  end

  generate
    for (gi = 0; gi < NRD; gi++) begin : g_rport
      logic [AW-1:0] ra;
      logic          hit;
      logic [DW-1:0] byp;
      logic [DW-1:0] rd_val;
      logic          rb_val;

      assign ra = raddr[gi*AW +: AW];

      always_comb begin
        hit = 1'b0;
        byp = '0;
        for (int j = 0; j < NWR; j++) begin
          if (we[j] && (wa[j] == ra)) begin
            hit = 1'b1;
            byp = wd[j];
          end
        end
        rd_val = '0;
        rb_val = 1'b0;
        if (resetn && !(HAS_ZERO && (ra == '0))) begin
          rd_val = hit ? byp : rf[ra];
          rb_val = busy_reg[ra] && !hit;
        end
      end

      assign rdata[gi*DW +: DW] = rd_val;
      assign rbusy[gi]          = rb_val;
    end
  endgenerate

endmodule

// File: tb/tb_regfile_mp_bypass_sb.sv
// Random and directed bench for regfile_mp_bypass_sb: two configurations driven
// side by side and compared every cycle against an array-based reference model.
module tb_regfile_mp_bypass_sb;

  logic clk = 1'b0;
  logic resetn;
  always #5 clk = ~clk;

  // Config A: NRD=6, NWR=2, ZERO_REG=1
  logic [29:0]  raddr_a;
  logic [191:0] rdata_a;
  logic [5:0]   rbusy_a;
  logic [1:0]   we_a, set_en_a;
  logic [9:0]   waddr_a, set_addr_a;
  logic [63:0]  wdata_a;
  // Config B: NRD=4, NWR=3, ZERO_REG=0
  logic [19:0]  raddr_b;
  logic [127:0] rdata_b;
  logic [3:0]   rbusy_b;
  logic [2:0]   we_b, set_en_b;
  logic [14:0]  waddr_b, set_addr_b;
  logic [95:0]  wdata_b;

  regfile_mp_bypass_sb dut_a (
    .clk(clk), .resetn(resetn), .raddr(raddr_a), .rdata(rdata_a), .rbusy(rbusy_a),
    .we(we_a), .waddr(waddr_a), .wdata(wdata_a), .set_en(set_en_a), .set_addr(set_addr_a)
  );

  regfile_mp_bypass_sb #(.NRD(4), .NWR(3), .ZERO_REG(0)) dut_b (
    .clk(clk), .resetn(resetn), .raddr(raddr_b), .rdata(rdata_b), .rbusy(rbusy_b),
    .we(we_b), .waddr(waddr_b), .wdata(wdata_b), .set_en(set_en_b), .set_addr(set_addr_b)
  );

  // Stimulus per configuration c (0=A, 1=B)
  logic [4:0]  ra  [2][6];
  logic        wen [2][3];
  logic [4:0]  wa  [2][3];
  logic [31:0] wd  [2][3];
  logic        sen [2][3];
  logic [4:0]  sa  [2][3];

  always_comb begin
    raddr_a = '0; we_a = '0; waddr_a = '0; wdata_a = '0; set_en_a = '0; set_addr_a = '0;
    for (int i = 0; i < 6; i++) raddr_a[i*5 +: 5] = ra[0][i];
    for (int j = 0; j < 2; j++) begin
      we_a[j] = wen[0][j]; waddr_a[j*5 +: 5] = wa[0][j]; wdata_a[j*32 +: 32] = wd[0][j];
      set_en_a[j] = sen[0][j]; set_addr_a[j*5 +: 5] = sa[0][j];
    end
  end

  always_comb begin
    raddr_b = '0; we_b = '0; waddr_b = '0; wdata_b = '0; set_en_b = '0; set_addr_b = '0;
    for (int i = 0; i < 4; i++) raddr_b[i*5 +: 5] = ra[1][i];
    for (int j = 0; j < 3; j++) begin
      we_b[j] = wen[1][j]; waddr_b[j*5 +: 5] = wa[1][j]; wdata_b[j*32 +: 32] = wd[1][j];
      set_en_b[j] = sen[1][j]; set_addr_b[j*5 +: 5] = sa[1][j];
    end
  end

  // Reference model: architectural register values and busy flags
  logic [31:0] mrf   [2][32];
  logic        mbusy [2][32];
  int n_vec = 0;
  int n_err = 0;

  function automatic int nrd_of(int c); return (c == 0) ? 6 : 4; endfunction
  function automatic int nwr_of(int c); return (c == 0) ? 2 : 3; endfunction
  function automatic bit zr_of(int c);  return (c == 0); endfunction

  function automatic logic [31:0] exp_rd(int c, logic [4:0] a);
    logic [31:0] v;
    if (resetn !== 1'b1) return 32'h0;
    if (zr_of(c) && a == 5'd0) return 32'h0;
    v = mrf[c][a];
    for (int j = 0; j < nwr_of(c); j++)
      if (wen[c][j] && wa[c][j] == a) v = wd[c][j];
    return v;
  endfunction

  function automatic logic exp_busy(int c, logic [4:0] a);
    logic b;
    if (resetn !== 1'b1) return 1'b0;
    if (zr_of(c) && a == 5'd0) return 1'b0;
    b = mbusy[c][a];
    for (int j = 0; j < nwr_of(c); j++)
      if (wen[c][j] && wa[c][j] == a) b = 1'b0;
    return b;
  endfunction

  task automatic check(input string tag, input int idx, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s[%0d] t=%0t got=%h expected=%h", tag, idx, $time, got, exp);
    end
  endtask

  task automatic model_update();
    for (int c = 0; c < 2; c++) begin
      if (!resetn) begin
        for (int r = 0; r < 32; r++) begin mrf[c][r] = 32'h0; mbusy[c][r] = 1'b0; end
      end else begin
        for (int j = 0; j < nwr_of(c); j++)
          if (wen[c][j] && !(zr_of(c) && wa[c][j] == 5'd0)) mrf[c][wa[c][j]] = wd[c][j];
        for (int j = 0; j < nwr_of(c); j++)
          if (wen[c][j] && !(zr_of(c) && wa[c][j] == 5'd0)) mbusy[c][wa[c][j]] = 1'b0;
        for (int k = 0; k < nwr_of(c); k++)
          if (sen[c][k] && !(zr_of(c) && sa[c][k] == 5'd0)) mbusy[c][sa[c][k]] = 1'b1;
      end
    end
  endtask

  task automatic sample();
    @(negedge clk);
    for (int i = 0; i < 6; i++) begin
      check("A.rdata", i, rdata_a[i*32 +: 32], exp_rd(0, ra[0][i]));
      check("A.rbusy", i, {31'b0, rbusy_a[i]}, {31'b0, exp_busy(0, ra[0][i])});
    end
    for (int i = 0; i < 4; i++) begin
      check("B.rdata", i, rdata_b[i*32 +: 32], exp_rd(1, ra[1][i]));
      check("B.rbusy", i, {31'b0, rbusy_b[i]}, {31'b0, exp_busy(1, ra[1][i])});
    end
  endtask

  task automatic advance();
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic clear_inputs();
    for (int c = 0; c < 2; c++) begin
      for (int i = 0; i < 6; i++) ra[c][i] = 5'd0;
      for (int j = 0; j < 3; j++) begin
        wen[c][j] = 1'b0; wa[c][j] = 5'd0; wd[c][j] = 32'h0; sen[c][j] = 1'b0; sa[c][j] = 5'd0;
      end
    end
  endtask

  function automatic logic [4:0] rand_addr();
    return ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 7));
  endfunction

  task automatic randomize_inputs();
    resetn = ($urandom_range(0, 499) == 0) ? 1'b0 : 1'b1;
    for (int c = 0; c < 2; c++) begin
      for (int i = 0; i < 6; i++) ra[c][i] = rand_addr();
      for (int j = 0; j < 3; j++) begin
        wen[c][j] = 1'($urandom_range(0, 1));
        wa[c][j]  = rand_addr();
        wd[c][j]  = $urandom;
        sen[c][j] = ($urandom_range(0, 9) < 3);
        sa[c][j]  = rand_addr();
      end
    end
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog expired t=%0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    for (int c = 0; c < 2; c++)
      for (int r = 0; r < 32; r++) begin mrf[c][r] = 32'h0; mbusy[c][r] = 1'b0; end
    resetn = 1'b1;
    clear_inputs();
    #1;

    // Reset with writes and sets asserted: everything must read 0 and stay 0
    resetn = 1'b0;
    wen[0][0] = 1'b1; wa[0][0] = 5'd3; wd[0][0] = 32'hAAAA_0003;
    wen[0][1] = 1'b1; wa[0][1] = 5'd4; wd[0][1] = 32'hBBBB_0004;
    sen[0][0] = 1'b1; sa[0][0] = 5'd3; sen[0][1] = 1'b1; sa[0][1] = 5'd4;
    ra[0][0] = 5'd3; ra[0][1] = 5'd4;
    sample();
    check("rst_rdata_any", 0, {31'b0, |rdata_a}, 32'h0);
    check("rst_rbusy_any", 0, {31'b0, |rbusy_a}, 32'h0);
    $display("txn reset_hold rdata_a=%h rbusy_a=%b", rdata_a[63:0], rbusy_a);
    advance();
    sample();
    advance();
    resetn = 1'b1;
    clear_inputs();
    ra[0][0] = 5'd3; ra[0][1] = 5'd4;
    sample();
    check("post_rst_r3", 0, rdata_a[0 +: 32], 32'h0);
    check("post_rst_r4", 1, rdata_a[32 +: 32], 32'h0);
    check("post_rst_busy", 0, {30'b0, rbusy_a[1:0]}, 32'h0);
    $display("txn reset_release r3=%h r4=%h", rdata_a[0 +: 32], rdata_a[32 +: 32]);
    advance();

    // Bypass of a same-cycle write, then the stored value
    wen[0][0] = 1'b1; wa[0][0] = 5'd7; wd[0][0] = 32'hDEAD_BEEF; ra[0][0] = 5'd7;
    sample();
    check("bypass_r7", 0, rdata_a[0 +: 32], 32'hDEAD_BEEF);
    $display("txn bypass r7=%h", rdata_a[0 +: 32]);
    advance();
    clear_inputs(); ra[0][0] = 5'd7;
    sample();
    check("stored_r7", 0, rdata_a[0 +: 32], 32'hDEAD_BEEF);
    $display("txn stored r7=%h", rdata_a[0 +: 32]);
    advance();

    // Write-port collision: highest port wins
    wen[0][0] = 1'b1; wa[0][0] = 5'd9; wd[0][0] = 32'h11;
    wen[0][1] = 1'b1; wa[0][1] = 5'd9; wd[0][1] = 32'h22; ra[0][1] = 5'd9;
    sample();
    check("coll_bypass_r9", 1, rdata_a[32 +: 32], 32'h22);
    $display("txn collision_bypass r9=%h", rdata_a[32 +: 32]);
    advance();
    clear_inputs(); ra[0][1] = 5'd9;
    sample();
    check("coll_stored_r9", 1, rdata_a[32 +: 32], 32'h22);
    $display("txn collision_stored r9=%h", rdata_a[32 +: 32]);
    advance();

    // Zero register ignores writes and sets
    wen[0][0] = 1'b1; wa[0][0] = 5'd0; wd[0][0] = 32'hFFFF_FFFF;
    sen[0][0] = 1'b1; sa[0][0] = 5'd0; ra[0][2] = 5'd0;
    sample();
    check("r0_same_cycle", 2, rdata_a[64 +: 32], 32'h0);
    advance();
    clear_inputs(); ra[0][2] = 5'd0;
    for (int n = 0; n < 2; n++) begin
      sample();
      check("r0_rdata", n, rdata_a[64 +: 32], 32'h0);
      check("r0_rbusy", n, {31'b0, rbusy_a[2]}, 32'h0);
      $display("txn zero_reg cyc%0d rdata=%h rbusy=%b", n, rdata_a[64 +: 32], rbusy_a[2]);
      advance();
    end

    // Scoreboard: set r12, busy from next cycle, cleared by a write three cycles later
    clear_inputs(); ra[0][3] = 5'd12; sen[0][0] = 1'b1; sa[0][0] = 5'd12;
    sample();
    check("sb_set_not_yet", 3, {31'b0, rbusy_a[3]}, 32'h0);
    advance();
    clear_inputs(); ra[0][3] = 5'd12;
    for (int n = 1; n <= 2; n++) begin
      sample();
      check("sb_busy", n, {31'b0, rbusy_a[3]}, 32'h1);
      $display("txn sb t+%0d rbusy=%b", n, rbusy_a[3]);
      advance();
    end
    wen[0][0] = 1'b1; wa[0][0] = 5'd12; wd[0][0] = 32'h55;
    sample();
    check("sb_wb_ready", 3, {31'b0, rbusy_a[3]}, 32'h0);
    check("sb_wb_data", 3, rdata_a[96 +: 32], 32'h55);
    $display("txn sb t+3 rbusy=%b rdata=%h", rbusy_a[3], rdata_a[96 +: 32]);
    advance();
    clear_inputs(); ra[0][3] = 5'd12;
    sample();
    check("sb_after_wb", 4, {31'b0, rbusy_a[3]}, 32'h0);
    advance();
    // Set and clear of r12 in one cycle: set wins
    sen[0][0] = 1'b1; sa[0][0] = 5'd12;
    wen[0][1] = 1'b1; wa[0][1] = 5'd12; wd[0][1] = 32'h66;
    sample();
    check("sb_setclr_now", 5, {31'b0, rbusy_a[3]}, 32'h0);
    advance();
    clear_inputs(); ra[0][3] = 5'd12;
    sample();
    check("sb_setclr_next", 6, {31'b0, rbusy_a[3]}, 32'h1);
    check("sb_setclr_data", 6, rdata_a[96 +: 32], 32'h66);
    $display("txn sb set+we rbusy=%b rdata=%h", rbusy_a[3], rdata_a[96 +: 32]);
    advance();

    // Random traffic on both configurations
    for (int cyc = 0; cyc < 10000; cyc++) begin
      randomize_inputs();
      sample();
      advance();
      if (cyc % 1000 == 999)
        $display("txn random cycles=%0d vectors=%0d miscompares=%0d", cyc + 1, n_vec, n_err);
    end
    resetn = 1'b1;
    clear_inputs();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
